nios_key_in_0: RTL and testbench

NIOS_KEY_IN_0 -- requirements
Module: nios_key_in_0

---
 rtl/nios_key_in_0.sv | 114 +++++++++++
 tb/tb_nios_key_in_0.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nios_key_in_0.sv
// Debounced key input port with edge capture and interrupt.
// Avalon-MM slave: DATA, IRQMASK, reserved, EDGECAP (W1C).
module nios_key_in_0 #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr_en;
  logic             unused_ok;

  assign wr_en     = chipselect & ~write_n;
  assign unused_ok = ^writedata;

  // Two-flop synchronizer plus delayed copy of the debounced level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= RESET_VALUE;
      s2   <= RESET_VALUE;
      db_d <= RESET_VALUE;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      db_d <= db;
    end
  end

  // Per-bit debounce: flip db after DEBOUNCE_CYCLES mismatching clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Edge detect on the debounced level, filtered by direction
  always_comb begin
    evt = '0;
    case (EDGE_TYPE)
      0:       evt = db & ~db_d;
      1:       evt = ~db & db_d;
      default: evt = db ^ db_d;
    endcase
  end

  // Write-one-to-clear mask for the capture register
  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3)
      clr = writedata[WIDTH-1:0];
  end

  // Interrupt mask and edge capture; a new event beats a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && address == 2'd1)
        irq_mask <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr) | evt;
    end
  end

  // Zero-latency read mux, decoded from address only
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = db;
      2'd1:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_key_in_0.sv
// Directed bench for nios_key_in_0 (falling-edge and both-edge
// instances driven from one shared bus).
module tb_nios_key_in_0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata2;
  logic        irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_key_in_0 #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1), .RESET_VALUE(4'hF)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  nios_key_in_0 #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(2), .RESET_VALUE(4'hF)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata2), .irq(irq2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d,
                    input logic cs);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_port    = 4'hF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    tick(2);
    rd(0); chk("rst_data_in", readdata, 32'hF);
    chk("rst_irq_in", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    rd(0); chk("rst_data", readdata, 32'hF);
    rd(1); chk("rst_mask", readdata, 32'h0);
    rd(3); chk("rst_cap", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    wr(1, 32'h1, 1'b1);
    rd(1); chk("mask_wr", readdata, 32'h1);
    wr(1, 32'h0, 1'b0);
    rd(1); chk("mask_nocs", readdata, 32'h1);
    wr(0, 32'h0, 1'b1);
    rd(0); chk("data_ro", readdata, 32'hF);
    wr(2, 32'hF, 1'b1);
    rd(2); chk("rsvd", readdata, 32'h0);

    // bit 0 falls, held
    in_port = 4'hE;
    tick(5);
    rd(0); chk("fall_e4", readdata, 32'hF);
    tick(1);
    rd(0); chk("fall_e5", readdata, 32'hE);
    rd(3); chk("fall_cap_e5", readdata, 32'h0);
    chk("fall_irq_e5", {31'b0, irq}, 32'h0);
    tick(1);
    rd(3); chk("fall_cap_e6", readdata, 32'h1);
    chk("fall_irq_e6", {31'b0, irq}, 32'h1);
    chk("fall_irq2_e6", {31'b0, irq2}, 32'h1);
    wr(3, 32'h1, 1'b1);
    rd(3); chk("w1c_cap", readdata, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    chk("w1c_irq2", {31'b0, irq2}, 32'h0);

    // 3-clock glitch on bit 1
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(10);
    rd(0); chk("glitch_data", readdata, 32'hE);
    rd(3); chk("glitch_cap", readdata, 32'h0);
    chk("glitch_cap2", readdata2, 32'h0);

    // bit 2 low then high
    in_port = 4'hA;
    tick(12);
    rd(0); chk("b2lo_data", readdata, 32'hA);
    rd(3); chk("b2lo_cap", readdata, 32'h4);
    chk("b2lo_cap2", readdata2, 32'h4);
    wr(3, 32'hF, 1'b1);
    in_port = 4'hE;
    tick(12);
    rd(0); chk("b2hi_data", readdata, 32'hE);
    rd(3); chk("b2hi_cap", readdata, 32'h0);
    chk("b2hi_cap2", readdata2, 32'h4);
    chk("b2hi_irq2", {31'b0, irq2}, 32'h0);
    wr(3, 32'hF, 1'b1);
    rd(3); chk("b2_clr2", readdata2, 32'h0);

    // set and clear on the same edge
    in_port = 4'hF;
    tick(12);
    rd(0); chk("b0hi_data", readdata, 32'hF);
    rd(3); chk("b0hi_cap", readdata, 32'h0);
    chk("b0hi_cap2", readdata2, 32'h1);
    wr(3, 32'hF, 1'b1);
    in_port = 4'hE;
    tick(6);
    wr(3, 32'h1, 1'b1);
    rd(3); chk("setwin_cap", readdata, 32'h1);
    chk("setwin_cap2", readdata2, 32'h1);
    chk("setwin_irq", {31'b0, irq}, 32'h1);
    wr(3, 32'hF, 1'b1);
    rd(3); chk("setwin_clr", readdata, 32'h0);
    wr(1, 32'hFFFF_FFFF, 1'b1);
    rd(1); chk("mask_width", readdata, 32'hF);

    // reset in the middle of a debounce
    in_port = 4'hC;
    tick(4);
    reset_n = 1'b0;
    #1;
    rd(0); chk("mid_rst_data", readdata, 32'hF);
    rd(1); chk("mid_rst_mask", readdata, 32'h0);
    rd(3); chk("mid_rst_cap", readdata, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    rd(3); chk("rel_cap", readdata, 32'h0);
    rd(0); chk("rel_data", readdata, 32'hF);
    tick(4);
    rd(0); chk("rel_data_e4", readdata, 32'hF);
    tick(1);
    rd(0); chk("rel_data_e5", readdata, 32'hC);
    tick(1);
    rd(3); chk("rel_cap_e6", readdata, 32'h3);
    chk("rel_irq_e6", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
